cmd_cfg: RTL and testbench

Command sequencer between the UART command receiver and the flight datapath. Decodes one opcode+data frame at a time and writes setpoints to the flight controller. Sequences the battery A2D conversion and the inertial calibration. Owns the motor-off latch, returns one response byte per command, and forces an emergency land on command-link loss.

---
 rtl/quad_pkg.sv | 28 ++
 rtl/cmd_wdog.sv | 38 +++
 rtl/cmd_cfg.sv | 197 +++++++++++++++++++
 tb/tb_cmd_cfg.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadcopter command path.
// Holds the command opcode enum (also used by the UART and flight-side
// blocks), the response byte constants and the sequencer state enum.
package quad_pkg;

    typedef enum logic [7:0] {
        OP_REQ_BATT  = 8'h01,
        OP_SET_PTCH  = 8'h02,
        OP_SET_ROLL  = 8'h03,
        OP_SET_YAW   = 8'h04,
        OP_SET_THRST = 8'h05,
        OP_CALIBRATE = 8'h06,
        OP_EMER_LAND = 8'h07,
        OP_MTRS_OFF  = 8'h08
    } opcode_t;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BATT,
        ST_SPINUP,
        ST_CAL,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cmd_wdog.sv
// Command-link watchdog: saturating up-counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : count enable (sequencer idle)
//   i_clr      : synchronous clear (a frame was consumed); wins over i_en
//   o_tc       : terminal count reached while enabled
// Terminal count is 2^10 cycles with FAST_SIM != 0, otherwise 2^26.
module cmd_wdog #(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int WD_W = (FAST_SIM != 0) ? 10 : 26;

    logic [WD_W-1:0] r_cnt;
    logic            w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_full) begin
            r_cnt <= r_cnt + WD_W'(1);
        end
    end

    // All-ones is the 2^WD_W-th idle cycle; it stays asserted while saturated.
    assign o_tc = i_en & w_full;

endmodule

// File: rtl/cmd_cfg.sv
// Command sequencer between the UART command receiver and the flight
// datapath. Decodes one opcode+data frame at a time, writes setpoints,
// sequences battery conversion and inertial calibration, owns the
// motor-off latch, returns one response byte per command and zeroes the
// setpoints when the command link goes quiet.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_rdy, cmd, data         : pending frame from the UART receiver
//   clr_cmd_rdy                : consumes the pending frame (same cycle)
//   resp, send_resp, resp_sent : response byte handshake with the transmitter
//   d_ptch, d_roll, d_yaw      : signed attitude setpoints
//   thrst                      : thrust setpoint
//   batt, strt_cnv, cnv_cmplt  : battery A2D handshake
//   inertial_cal, strt_cal,
//   cal_done                   : calibration sequencing
//   motors_off                 : ESC outputs forced off
module cmd_cfg
    import quad_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic               resp_sent,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    input  logic [7:0]         batt,
    output logic               strt_cnv,
    input  logic               cnv_cmplt,
    output logic               inertial_cal,
    output logic               strt_cal,
    input  logic               cal_done,
    output logic               motors_off
);

    localparam int SPIN_W = (FAST_SIM != 0) ? 9 : 25;

    state_t             r_state;
    logic signed [15:0] r_d_ptch;
    logic signed [15:0] r_d_roll;
    logic signed [15:0] r_d_yaw;
    logic [8:0]         r_thrst;
    logic [7:0]         r_resp;
    logic               r_send_resp;
    logic               r_strt_cnv;
    logic               r_strt_cal;
    logic               r_inertial_cal;
    logic               r_motors_off;
    logic [SPIN_W-1:0]  r_spin;

    logic               w_consume;
    logic               w_idle;
    logic               w_wd_tc;

    assign w_idle    = (r_state == ST_IDLE);
    // Frame is taken in the same cycle it is seen so the receiver can drop
    // cmd_rdy before the next edge.
    assign w_consume = w_idle & cmd_rdy;

    cmd_wdog #(
        .FAST_SIM (FAST_SIM)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_idle),
        .i_clr (w_consume),
        .o_tc  (w_wd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_d_ptch       <= '0;
            r_d_roll       <= '0;
            r_d_yaw        <= '0;
            r_thrst        <= '0;
            r_resp         <= '0;
            r_send_resp    <= 1'b0;
            r_strt_cnv     <= 1'b0;
            r_strt_cal     <= 1'b0;
            r_inertial_cal <= 1'b0;
            r_motors_off   <= 1'b1;
            r_spin         <= '0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle
            // on the transition that calls for it.
            r_send_resp <= 1'b0;
            r_strt_cnv  <= 1'b0;
            r_strt_cal  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_rdy) begin
                        r_state     <= ST_RESP;
                        r_send_resp <= 1'b1;
                        r_resp      <= RESP_ACK;
                        case (cmd)
                            OP_SET_PTCH:  r_d_ptch <= data;
                            OP_SET_ROLL:  r_d_roll <= data;
                            OP_SET_YAW:   r_d_yaw  <= data;
                            OP_SET_THRST: r_thrst  <= data[8:0];
                            OP_EMER_LAND: begin
                                r_d_ptch <= '0;
                                r_d_roll <= '0;
                                r_d_yaw  <= '0;
                                r_thrst  <= '0;
                            end
                            OP_MTRS_OFF:  r_motors_off <= 1'b1;
                            OP_REQ_BATT: begin
                                r_state     <= ST_BATT;
                                r_send_resp <= 1'b0;
                                r_resp      <= r_resp;
                                r_strt_cnv  <= 1'b1;
                            end
                            OP_CALIBRATE: begin
                                r_state        <= ST_SPINUP;
                                r_send_resp    <= 1'b0;
                                r_resp         <= r_resp;
                                r_motors_off   <= 1'b0;
                                r_d_ptch       <= '0;
                                r_d_roll       <= '0;
                                r_d_yaw        <= '0;
                                r_thrst        <= '0;
                                r_inertial_cal <= 1'b1;
                                r_spin         <= '0;
                            end
                            default:      r_resp <= RESP_NACK;
                        endcase
                    end else if (w_wd_tc) begin
                        // Link lost: land. Latch and response untouched.
                        r_d_ptch <= '0;
                        r_d_roll <= '0;
                        r_d_yaw  <= '0;
                        r_thrst  <= '0;
                    end
                end

                ST_BATT: begin
                    if (cnv_cmplt) begin
                        r_resp      <= batt;
                        r_send_resp <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_SPINUP: begin
                    // Timer is 0 on the first spin-up cycle, so all-ones marks
                    // the last of 2^SPIN_W cycles.
                    if (&r_spin) begin
                        r_strt_cal <= 1'b1;
                        r_state    <= ST_CAL;
                    end else begin
                        r_spin <= r_spin + SPIN_W'(1);
                    end
                end

                ST_CAL: begin
                    if (cal_done) begin
                        r_inertial_cal <= 1'b0;
                        r_resp         <= RESP_ACK;
                        r_send_resp    <= 1'b1;
                        r_state        <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (resp_sent) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign clr_cmd_rdy  = w_consume;
    assign resp         = r_resp;
    assign send_resp    = r_send_resp;
    assign d_ptch       = r_d_ptch;
    assign d_roll       = r_d_roll;
    assign d_yaw        = r_d_yaw;
    assign thrst        = r_thrst;
    assign strt_cnv     = r_strt_cnv;
    assign strt_cal     = r_strt_cal;
    assign inertial_cal = r_inertial_cal;
    assign motors_off   = r_motors_off;

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg (FAST_SIM = 1).
// A high-level model tracks setpoints, the motor-off latch, the calibrate
// flag and idle time; one process compares it with the DUT every cycle,
// and the directed sequence adds literal expectations and pulse timing.
module tb_cmd_cfg;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_rdy;
    logic [7:0]         cmd;
    logic [15:0]        data;
    logic               clr_cmd_rdy;
    logic [7:0]         resp;
    logic               send_resp;
    logic               resp_sent;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic [8:0]         thrst;
    logic [7:0]         batt;
    logic               strt_cnv;
    logic               cnv_cmplt;
    logic               inertial_cal;
    logic               strt_cal;
    logic               cal_done;
    logic               motors_off;

    cmd_cfg #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .resp_sent    (resp_sent),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .batt         (batt),
        .strt_cnv     (strt_cnv),
        .cnv_cmplt    (cnv_cmplt),
        .inertial_cal (inertial_cal),
        .strt_cal     (strt_cal),
        .cal_done     (cal_done),
        .motors_off   (motors_off)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_moff, m_ical;
    bit          m_on   = 0;
    bit          m_idle = 0;
    int          m_idle_cnt = 0;
    int          n_send = 0, n_cnv = 0, n_cal = 0;

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
        m_moff = 1; m_ical = 0;
        m_idle = 1; m_idle_cnt = 0;
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [15:0] dat);
        case (op)
            8'h02: m_ptch = dat;
            8'h03: m_roll = dat;
            8'h04: m_yaw  = dat;
            8'h05: m_thrst = dat[8:0];
            8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
            8'h08: m_moff = 1;
            8'h06: begin
                m_moff = 0; m_ical = 1;
                m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
            end
            default: ;
        endcase
    endtask

    // 1024 idle cycles without a frame land the craft.
    always @(posedge clk) begin
        if (rst_n && m_idle && !cmd_rdy) begin
            m_idle_cnt++;
            if (m_idle_cnt >= 1024) begin
                m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
            end
        end
    end

    // Per-cycle compare and pulse counting.
    always @(negedge clk) begin
        if (m_on) begin
            chk("cyc_d_ptch", d_ptch, m_ptch);
            chk("cyc_d_roll", d_roll, m_roll);
            chk("cyc_d_yaw", d_yaw, m_yaw);
            chk("cyc_thrst", {7'b0, thrst}, {7'b0, m_thrst});
            chk("cyc_motors_off", {15'b0, motors_off}, {15'b0, m_moff});
            chk("cyc_inertial_cal", {15'b0, inertial_cal}, {15'b0, m_ical});
        end
        if (rst_n === 1'b1) begin
            n_send += int'(send_resp);
            n_cnv  += int'(strt_cnv);
            n_cal  += int'(strt_cal);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic consume(input logic [7:0] op, input logic [15:0] dat);
        @(negedge clk);
        chk("clr_cmd_rdy", {15'b0, clr_cmd_rdy}, 16'h1);
        @(posedge clk); #1;
        cmd_rdy = 0;
        m_idle  = 0;
        model_cmd(op, dat);
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] dat);
        cmd = op; data = dat; cmd_rdy = 1;
        consume(op, dat);
    endtask

    task automatic expect_resp(input string nm, input logic [7:0] exp);
        @(negedge clk);
        chk({nm, "_send"}, {15'b0, send_resp}, 16'h1);
        chk({nm, "_resp"}, {8'b0, resp}, {8'b0, exp});
        chk({nm, "_noclr"}, {15'b0, clr_cmd_rdy}, 16'h0);
        @(posedge clk); #1;
        resp_sent = 1;
        @(negedge clk);
        chk({nm, "_send_1cyc"}, {15'b0, send_resp}, 16'h0);
        chk({nm, "_resp_hold"}, {8'b0, resp}, {8'b0, exp});
        @(posedge clk); #1;
        resp_sent  = 0;
        m_idle     = 1;
        m_idle_cnt = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        bit found;
        int s0, c0, l0;

        rst_n = 0; cmd_rdy = 0; cmd = 0; data = 0; resp_sent = 0;
        batt = 8'h11; cnv_cmplt = 0; cal_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 m_on = 1;

        // Reset state
        @(negedge clk);
        chk("rst_motors_off", {15'b0, motors_off}, 16'h1);
        chk("rst_d_ptch", d_ptch, 16'h0);
        chk("rst_thrst", {7'b0, thrst}, 16'h0);
        chk("rst_resp", {8'b0, resp}, 16'h0);
        chk("rst_pulses", {12'b0, send_resp, strt_cnv, strt_cal, clr_cmd_rdy}, 16'h0);
        chk("rst_inertial_cal", {15'b0, inertial_cal}, 16'h0);
        @(posedge clk); #1;
        rst_n = 1; m_idle = 1; m_idle_cnt = 0;
        tick(2);

        // Setpoint writes
        issue(8'h02, 16'h00FA);
        expect_resp("ptch", 8'hA5);
        chk("ptch_val", d_ptch, 16'h00FA);
        issue(8'h05, 16'hFFFD);
        expect_resp("thrst", 8'hA5);
        chk("thrst_val", {7'b0, thrst}, 16'h01FD);

        // Stray completion strobes in IDLE are ignored
        cnv_cmplt = 1; cal_done = 1; resp_sent = 1;
        tick(1);
        cnv_cmplt = 0; cal_done = 0; resp_sent = 0;
        @(negedge clk);
        chk("stray_no_send", {15'b0, send_resp}, 16'h0);
        tick(1);

        // REQ_BATT with a second frame arriving during BATT
        c0 = n_cnv; s0 = n_send;
        issue(8'h01, 16'h0000);
        @(negedge clk);
        chk("batt_strt_cnv", {15'b0, strt_cnv}, 16'h1);
        chk("batt_no_send", {15'b0, send_resp}, 16'h0);
        cmd = 8'h03; data = 16'h1234; cmd_rdy = 1;
        @(posedge clk); #1;
        resp_sent = 1; cal_done = 1;
        @(negedge clk);
        chk("batt_cnv_1cyc", {15'b0, strt_cnv}, 16'h0);
        chk("batt_hold_frame", {15'b0, clr_cmd_rdy}, 16'h0);
        chk("batt_early_send", {15'b0, send_resp}, 16'h0);
        @(posedge clk); #1;
        resp_sent = 0; cal_done = 0;
        tick(3);
        batt = 8'hC0; cnv_cmplt = 1;
        @(negedge clk);
        chk("batt_hold_frame2", {15'b0, clr_cmd_rdy}, 16'h0);
        @(posedge clk); #1;
        cnv_cmplt = 0;
        expect_resp("batt", 8'hC0);
        chk("batt_cnv_count", 16'(n_cnv - c0), 16'h1);
        chk("batt_send_count", 16'(n_send - s0), 16'h1);
        consume(8'h03, 16'h1234);
        expect_resp("roll_pend", 8'hA5);
        chk("roll_val", d_roll, 16'h1234);

        // Motor-off latch survives setpoint writes
        issue(8'h08, 16'h0000);
        expect_resp("moff", 8'hA5);
        issue(8'h04, 16'h0010);
        expect_resp("yaw", 8'hA5);
        chk("yaw_val", d_yaw, 16'h0010);
        chk("moff_held", {15'b0, motors_off}, 16'h1);

        // Unknown opcode
        issue(8'h3C, 16'h7777);
        expect_resp("unknown", 8'hEE);
        chk("unknown_yaw", d_yaw, 16'h0010);
        chk("unknown_ptch", d_ptch, 16'h00FA);

        // CALIBRATE
        l0 = n_cal;
        issue(8'h06, 16'h0000);
        @(negedge clk);
        chk("cal_moff_clr", {15'b0, motors_off}, 16'h0);
        chk("cal_flag", {15'b0, inertial_cal}, 16'h1);
        chk("cal_ptch_zero", d_ptch, 16'h0);
        k = 0; found = 0;
        while (k < 600 && !found) begin
            if (strt_cal) found = 1;
            else begin
                @(posedge clk); #1;
                cal_done = (k == 99);
                k++;
                @(negedge clk);
            end
        end
        cal_done = 0;
        chk("spinup_len", 16'(k), 16'd512);
        @(posedge clk); #1;
        @(negedge clk);
        chk("strt_cal_1cyc", {15'b0, strt_cal}, 16'h0);
        tick(2);
        cal_done = 1;
        @(posedge clk); #1;
        cal_done = 0; m_ical = 0;
        expect_resp("cal", 8'hA5);
        chk("cal_flag_low", {15'b0, inertial_cal}, 16'h0);
        chk("cal_count", 16'(n_cal - l0), 16'h1);

        // Watchdog: frame on the terminal-count cycle wins
        issue(8'h02, 16'h0100);
        expect_resp("wd_ptch", 8'hA5);
        issue(8'h04, 16'hFF00);
        expect_resp("wd_yaw", 8'hA5);
        issue(8'h05, 16'h0033);
        expect_resp("wd_thrst", 8'hA5);
        tick(1023);
        issue(8'h03, 16'h0055);
        expect_resp("wd_tie", 8'hA5);
        chk("wd_tie_ptch", d_ptch, 16'h0100);
        chk("wd_tie_roll", d_roll, 16'h0055);
        s0 = n_send;
        tick(1000);
        @(negedge clk);
        chk("wd_before_ptch", d_ptch, 16'h0100);
        tick(30);
        @(negedge clk);
        chk("wd_ptch", d_ptch, 16'h0);
        chk("wd_roll", d_roll, 16'h0);
        chk("wd_yaw", d_yaw, 16'h0);
        chk("wd_thrst", {7'b0, thrst}, 16'h0);
        chk("wd_moff_kept", {15'b0, motors_off}, 16'h0);
        chk("wd_no_send", 16'(n_send - s0), 16'h0);
        tick(1);

        // Reset during SPINUP
        l0 = n_cal; s0 = n_send;
        issue(8'h06, 16'h0000);
        tick(100);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_async_ical", {15'b0, inertial_cal}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1; m_idle = 1; m_idle_cnt = 0;
        tick(600);
        @(negedge clk);
        chk("rst_no_strt_cal", 16'(n_cal - l0), 16'h0);
        chk("rst_no_send", 16'(n_send - s0), 16'h0);
        chk("rst_moff_set", {15'b0, motors_off}, 16'h1);
        tick(1);
        issue(8'h02, 16'h0042);
        expect_resp("post_rst", 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
